bypass_adder_pipe: RTL and testbench
====================================

Name: bypass_adder_pipe

Overview:
- Parametrised, pipelined carry-skip (bypass) adder; successor to the 32-bit/4-bit-block combinational bypass adder.
- Splits the skip-block chain into STAGES register-separated segments, so it can run in the datapath at full clock rate.
- Uses a valid/ready handshake on input and output, with a global stall.
- Sits between operand-fetch logic and result writeback in the arithmetic datapath.

Parameters:
- WIDTH, 32, operand/sum width in bits; must be a multiple of BLOCK.
- BLOCK, 4, bits per carry-skip block (ripple section plus skip mux).
- STAGES, 2, number of pipeline segments; must be 1 or more, and (WIDTH/BLOCK) must be divisible by STAGES.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operands A, B and Cin are valid.
- in_ready  out  1  block accepts operands this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Cin  in  1  carry-in.
- out_valid  out  1  Sum and Cout are valid.
- out_ready  in  1  downstream accepts the result.
- Sum  out  WIDTH  A+B+Cin, modulo 2^WIDTH.
- Cout  out  1  carry out of the MSB.
- Ovf  out  1  signed overflow; present only with BYPASS_ADDER_OVF_EN.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All stage valid bits clear; out_valid=0, Sum=0, Cout=0, Ovf=0.
  - in_ready=1 in the cycle after reset.
  - Reset mid-operation discards every in-flight result, with no partial output.
- Handshake:
  - Input transfer occurs when in_valid & in_ready at the clock edge.
  - Output transfer occurs when out_valid & out_ready.
  - Output is held stable (Sum, Cout, Ovf, out_valid) while out_valid=1 and out_ready=0.
- Global advance: adv = !out_valid | out_ready, and in_ready = adv.
  - When adv=0, every stage register holds; bubbles are not collapsed.
  - When adv=1, every stage shifts forward one position, and stage 0 loads in_valid plus its operands.
- Segments:
  - Segment k computes skip blocks k*(NB/STAGES) .. (k+1)*(NB/STAGES)-1, where NB=WIDTH/BLOCK.
  - Each segment uses the carry registered from segment k-1; segment 0 uses Cin.
  - Each segment's registers hold the sum bits already computed, the not-yet-consumed operand bits, the running carry and a valid bit.
- Skip block: block carry-out = P ? block carry-in : ripple carry-out, where P is the AND of (a_i ^ b_i) over the block.
- Latency:
  - A result accepted at edge N gives out_valid=1 after edge N+STAGES-1 registers the last segment. This is STAGES register stages, with no combinational input-to-output path.
  - Throughput is one result per cycle when out_ready stays high.
- Arithmetic:
  - Unsigned modulo-2^WIDTH sum; Cout is the true carry out of bit WIDTH-1.
  - The all-propagate case (A ^ B all ones) with Cin=1 must give Sum=0 and Cout=1 through the skip path.
- Simultaneous events:
  - rst=1 overrides handshakes.
  - in_valid=1 during a stall is not accepted; upstream must hold its operands.
  - out_ready=1 while out_valid=0 has no effect.
- Parameter-legality check at elaboration; if violated, the block issues a fatal error.

Optional Feature:
- BYPASS_ADDER_OVF_EN:
  - Defined: Ovf port exists and is registered alongside Sum; Ovf = (A[W-1] == B[W-1]) & (Sum[W-1] != A[W-1]). The required operand MSBs are carried through the pipeline.
  - Undefined: no Ovf port and no extra registers.

Decomposition:
- Package bypass_adder_pkg:
  - Default constants for WIDTH, BLOCK and STAGES.
  - Derived-constant function for NB and blocks-per-stage.
  - Legality-check function used by the elaboration check.
- One sub-module: bypass_skip_block, parametrised by BLOCK.
  - Purely combinational: BLOCK-bit ripple adder plus propagate AND plus skip mux.
  - Instantiated NB times across the segments.

Test Plan (WIDTH=32, BLOCK=4, STAGES=2):
- Carry ripple: A=FFFFFFFF, B=00000001, Cin=0, in_valid=1, out_ready=1 -> 2 cycles later out_valid=1, Sum=00000000, Cout=1.
- Full skip path: A=AAAAAAAA, B=55555555, Cin=1 -> Sum=00000000, Cout=1. The same operands with Cin=0 -> Sum=FFFFFFFF, Cout=0.
- Back-to-back throughput: issue 12345678+87654321+1, then 11111111+22222222+1, then FFFFFFFF+FFFFFFFF+0 on consecutive cycles -> results 9999999A/0, 33333334/0, FFFFFFFE/1 on three consecutive cycles.
- Stall: with out_valid=1, drop out_ready for 3 cycles -> in_ready=0, and outputs plus stage contents hold. Raise out_ready -> results drain in order, none lost or duplicated.
- Reset mid-flight: two operations in flight, assert rst for one edge -> out_valid=0, Sum=0, Cout=0 next cycle; no stale result ever appears.
- With BYPASS_ADDER_OVF_EN: 7FFFFFFF+00000001 -> Sum=80000000, Ovf=1, Cout=0; 80000000+FFFFFFFF -> Sum=7FFFFFFF, Ovf=1, Cout=1.

Source files
------------

// File: rtl/bypass_adder_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined carry-skip adder.
package bypass_adder_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_BLOCK  = 4;
    localparam int DEF_STAGES = 2;

    // Number of carry-skip blocks across the full operand width.
    function automatic int num_blocks(input int width, input int block);
        if (block <= 0) begin
            return 0;
        end
        return width / block;
    endfunction

    // Number of skip blocks handled by each pipeline segment.
    function automatic int blocks_per_stage(input int width, input int block, input int stages);
        if (stages <= 0) begin
            return 0;
        end
        return num_blocks(width, block) / stages;
    endfunction

    // True when the width/block/stage combination splits evenly into segments.
    function automatic bit params_legal(input int width, input int block, input int stages);
        if (width <= 0 || block <= 0 || stages < 1) begin
            return 1'b0;
        end
        if ((width % block) != 0) begin
            return 1'b0;
        end
        return ((width / block) % stages) == 0;
    endfunction

endpackage

// File: rtl/bypass_adder_pipe_if.sv
// Operand/result handshake bundle for bypass_adder_pipe.
// Ovf is only present when BYPASS_ADDER_OVF_EN is defined.
interface bypass_adder_pipe_if
    import bypass_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
`ifdef BYPASS_ADDER_OVF_EN
    logic             Ovf;
`endif

`ifdef BYPASS_ADDER_OVF_EN
    modport master (
        output in_valid, A, B, Cin, out_ready,
        input  in_ready, out_valid, Sum, Cout, Ovf
    );

    modport slave (
        input  in_valid, A, B, Cin, out_ready,
        output in_ready, out_valid, Sum, Cout, Ovf
    );
`else
    modport master (
        output in_valid, A, B, Cin, out_ready,
        input  in_ready, out_valid, Sum, Cout
    );

    modport slave (
        input  in_valid, A, B, Cin, out_ready,
        output in_ready, out_valid, Sum, Cout
    );
`endif

endinterface

// File: rtl/bypass_skip_block.sv
// One carry-skip block: BLOCK-bit ripple section plus a skip mux that forwards
// the block carry-in directly when every bit position propagates.
module bypass_skip_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] s,
    output logic             cout
);

    logic [BLOCK-1:0] p_bits;
    logic             ripple_cout;

    assign p_bits = a ^ b;

    // Ripple the carry through the block, producing sum bits and the slow carry-out.
    always_comb begin : ripple
        logic c;
        c = cin;
        s = '0;
        for (int i = 0; i < BLOCK; i++) begin
            s[i] = p_bits[i] ^ c;
            c    = (a[i] & b[i]) | (c & p_bits[i]);
        end
        ripple_cout = c;
    end

    // When all positions propagate the ripple result equals cin anyway; the mux
    // just lets the carry skip the ripple chain.
    assign cout = (&p_bits) ? cin : ripple_cout;

endmodule

// File: rtl/bypass_adder_pipe.sv
// Pipelined carry-skip adder. The skip-block chain is cut into STAGES segments;
// segment 0 works on the incoming operands, segment k on the registers of
// segment k-1. A single advance signal moves the whole pipe or freezes it.
// Optional signed-overflow output: define BYPASS_ADDER_OVF_EN.
module bypass_adder_pipe
    import bypass_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int BLOCK  = DEF_BLOCK,
    parameter int STAGES = DEF_STAGES
) (
    input  logic                clk,
    input  logic                rst,
    bypass_adder_pipe_if.slave  bus
);

    localparam int BPS = blocks_per_stage(WIDTH, BLOCK, STAGES);
    localparam int SW  = BPS * BLOCK;

    if (!params_legal(WIDTH, BLOCK, STAGES)) begin : g_param_check
        $fatal(1, "bypass_adder_pipe: WIDTH must be a multiple of BLOCK and WIDTH/BLOCK a multiple of STAGES");
    end

    // Stage registers: operands still to be consumed, partial sum, running carry, valid.
    logic [WIDTH-1:0]  a_reg      [STAGES];
    logic [WIDTH-1:0]  b_reg      [STAGES];
    logic [WIDTH-1:0]  sum_reg    [STAGES];
    logic [STAGES-1:0] carry_reg;
    logic [STAGES-1:0] valid_reg;

    // Per-segment inputs (from the bus or the previous stage) and results.
    logic [WIDTH-1:0]  seg_a      [STAGES];
    logic [WIDTH-1:0]  seg_b      [STAGES];
    logic [WIDTH-1:0]  seg_sum_in [STAGES];
    logic [WIDTH-1:0]  next_sum   [STAGES];
    logic [STAGES-1:0] seg_cin;
    logic [STAGES-1:0] seg_vin;
    logic [STAGES-1:0] next_carry;

    logic adv;

    assign adv           = !valid_reg[STAGES-1] | bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = valid_reg[STAGES-1];
    assign bus.Sum       = sum_reg[STAGES-1];
    assign bus.Cout      = carry_reg[STAGES-1];

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_seg
        logic [SW-1:0] seg_s;

        if (gi == 0) begin : g_src
            assign seg_a[gi]      = bus.A;
            assign seg_b[gi]      = bus.B;
            assign seg_sum_in[gi] = '0;
            assign seg_cin[gi]    = bus.Cin;
            assign seg_vin[gi]    = bus.in_valid;
        end else begin : g_src
            assign seg_a[gi]      = a_reg[gi-1];
            assign seg_b[gi]      = b_reg[gi-1];
            assign seg_sum_in[gi] = sum_reg[gi-1];
            assign seg_cin[gi]    = carry_reg[gi-1];
            assign seg_vin[gi]    = valid_reg[gi-1];
        end

        for (genvar gj = 0; gj < BPS; gj++) begin : g_blk
            localparam int LSB = (gi * BPS + gj) * BLOCK;
            logic blk_cin;
            logic blk_cout;

            if (gj == 0) begin : g_cin
                assign blk_cin = seg_cin[gi];
            end else begin : g_cin
                assign blk_cin = g_blk[gj-1].blk_cout;
            end

            bypass_skip_block #(
                .BLOCK (BLOCK)
            ) u_skip (
                .a    (seg_a[gi][LSB +: BLOCK]),
                .b    (seg_b[gi][LSB +: BLOCK]),
                .cin  (blk_cin),
                .s    (seg_s[gj*BLOCK +: BLOCK]),
                .cout (blk_cout)
            );
        end

        // Bits above the current segment are still zero in the partial sum,
        // so the new segment can simply be OR-ed into place.
        assign next_carry[gi] = g_blk[BPS-1].blk_cout;
        assign next_sum[gi]   = seg_sum_in[gi] | (WIDTH'(seg_s) << (gi * SW));
    end

`ifdef BYPASS_ADDER_OVF_EN
    logic ovf_next;
    logic ovf_reg;

    // Operand MSBs reach the last segment through the operand registers.
    assign ovf_next = (seg_a[STAGES-1][WIDTH-1] == seg_b[STAGES-1][WIDTH-1]) &
                      (next_sum[STAGES-1][WIDTH-1] != seg_a[STAGES-1][WIDTH-1]);
    assign bus.Ovf  = ovf_reg;
`endif

    // Control and result registers: cleared on reset, shifted as a whole on advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
            carry_reg <= '0;
            for (int s = 0; s < STAGES; s++) begin
                sum_reg[s] <= '0;
            end
`ifdef BYPASS_ADDER_OVF_EN
            ovf_reg <= 1'b0;
`endif
        end else if (adv) begin
            valid_reg <= seg_vin;
            carry_reg <= next_carry;
            for (int s = 0; s < STAGES; s++) begin
                sum_reg[s] <= next_sum[s];
            end
`ifdef BYPASS_ADDER_OVF_EN
            ovf_reg <= ovf_next;
`endif
        end
    end

    // Operand pipeline: pure data, qualified by valid_reg, so no reset needed.
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int s = 0; s < STAGES; s++) begin
                a_reg[s] <= seg_a[s];
                b_reg[s] <= seg_b[s];
            end
        end
    end

    // The last stage's operand copy has no consumer; synthesis trims it.
    logic unused_ops;
    assign unused_ops = ^{a_reg[STAGES-1], b_reg[STAGES-1]};

endmodule

// File: tb/tb_bypass_adder_pipe.sv
// Self-checking bench for bypass_adder_pipe (WIDTH=32, BLOCK=4, STAGES=2).
// Define BYPASS_ADDER_OVF_EN to also exercise the overflow output.
module tb_bypass_adder_pipe;
    import bypass_adder_pkg::*;

    localparam int W   = 32;
    localparam int BLK = 4;
    localparam int S   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bypass_adder_pipe_if #(.WIDTH(W)) bus();

    bypass_adder_pipe #(
        .WIDTH  (W),
        .BLOCK  (BLK),
        .STAGES (S)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit check_en = 1'b0;

    // Reference: slots of the pipe, each holding {ovf, cout, sum} of a+b+cin.
    logic        m_v [S] = '{default: 1'b0};
    logic [33:0] m_r [S] = '{default: 34'h0};
    logic [33:0] exp_q   [$];
    logic [33:0] obs_res [$];
    int          obs_cyc [$];
    logic [33:0] got;
    logic        ovf_obs;

`ifdef BYPASS_ADDER_OVF_EN
    assign ovf_obs = bus.Ovf;
`else
    assign ovf_obs = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic cin);
        logic [32:0] t;
        logic        ov;
        t  = {1'b0, a} + {1'b0, b} + 33'(cin);
        ov = 1'b0;
`ifdef BYPASS_ADDER_OVF_EN
        ov = (a[31] == b[31]) && (t[31] != a[31]);
`endif
        return {ov, t};
    endfunction

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 7))
            0: return 32'hFFFF_FFFF;
            1: return 32'h0000_0000;
            2: return 32'hAAAA_AAAA;
            3: return 32'h5555_5555;
            default: return $urandom();
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference pipe: whole pipe moves when the last slot is empty or drained.
    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < S; s++) m_v[s] <= 1'b0;
            exp_q.delete();
        end else if (!m_v[S-1] || bus.out_ready) begin
            for (int s = S - 1; s > 0; s--) begin
                m_v[s] <= m_v[s-1];
                m_r[s] <= m_r[s-1];
            end
            m_v[0] <= bus.in_valid;
            m_r[0] <= ref_add(bus.A, bus.B, bus.Cin);
            if (bus.in_valid) exp_q.push_back(ref_add(bus.A, bus.B, bus.Cin));
        end
    end

    // Cycle-by-cycle comparison against the reference, plus transfer log.
    always @(negedge clk) begin
        if (check_en) begin
            got = {ovf_obs, bus.Cout, bus.Sum};
            check("out_valid", 64'(bus.out_valid), 64'(m_v[S-1]));
            check("in_ready", 64'(bus.in_ready), 64'(!m_v[S-1] || bus.out_ready));
            if (m_v[S-1]) check("result", 64'(got), 64'(m_r[S-1]));
            if (!rst && bus.out_valid && bus.out_ready) begin
                $display("xfer cyc=%0d sum=%h cout=%b ovf=%b", cyc, bus.Sum, bus.Cout, ovf_obs);
                obs_res.push_back(got);
                obs_cyc.push_back(cyc);
                check("sb_pending", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) check("sb_order", 64'(got), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic clear_obs();
        obs_res.delete();
        obs_cyc.delete();
    endtask

    task automatic wait_obs(input int n);
        for (int i = 0; i < 20 && obs_res.size() < n; i++) begin
            @(posedge clk); #1;
        end
        check("obs_count", 64'(obs_res.size()), 64'(n));
    endtask

    task automatic put(input logic v, input logic [31:0] a, input logic [31:0] b, input logic cin);
        bus.in_valid = v;
        bus.A        = a;
        bus.B        = b;
        bus.Cin      = cin;
    endtask

    // Single operation through an empty pipe, checked against fixed values.
    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b, input logic cin,
                           input logic [31:0] exp_sum, input logic exp_cout, input logic exp_ovf);
        int lat;
        clear_obs();
        put(1'b1, a, b, cin);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(S - 1));
        check({tag, "_sum"}, 64'(bus.Sum), 64'(exp_sum));
        check({tag, "_cout"}, 64'(bus.Cout), 64'(exp_cout));
`ifdef BYPASS_ADDER_OVF_EN
        check({tag, "_ovf"}, 64'(bus.Ovf), 64'(exp_ovf));
`else
        if (exp_ovf) begin
            // Overflow expectation only applies when the output exists.
        end
`endif
        @(posedge clk); #1;
        check({tag, "_xfers"}, 64'(obs_res.size()), 64'(1));
    endtask

    initial begin
        put(1'b0, 32'h0, 32'h0, 1'b0);
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_valid", 64'(bus.out_valid), 64'(0));
        check("reset_sum", 64'(bus.Sum), 64'(0));
        check("reset_cout", 64'(bus.Cout), 64'(0));
        check("reset_ready", 64'(bus.in_ready), 64'(1));
`ifdef BYPASS_ADDER_OVF_EN
        check("reset_ovf", 64'(bus.Ovf), 64'(0));
`endif
        check_en = 1'b1;

        run_one("ripple",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_one("skip_c1", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        run_one("skip_c0", 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
`ifdef BYPASS_ADDER_OVF_EN
        run_one("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_one("ovf_neg", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
`endif

        // Back-to-back throughput.
        clear_obs();
        put(1'b1, 32'h1234_5678, 32'h8765_4321, 1'b1);
        @(posedge clk); #1;
        put(1'b1, 32'h1111_1111, 32'h2222_2222, 1'b1);
        @(posedge clk); #1;
        put(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_obs(3);
        if (obs_res.size() >= 3) begin
            check("b2b_r0", 64'(obs_res[0][32:0]), 64'({1'b0, 32'h9999_999A}));
            check("b2b_r1", 64'(obs_res[1][32:0]), 64'({1'b0, 32'h3333_3334}));
            check("b2b_r2", 64'(obs_res[2][32:0]), 64'({1'b1, 32'hFFFF_FFFE}));
            check("b2b_gap01", 64'(obs_cyc[1] - obs_cyc[0]), 64'(1));
            check("b2b_gap12", 64'(obs_cyc[2] - obs_cyc[1]), 64'(1));
        end

        // Stall with a pending third operand held by upstream.
        clear_obs();
        bus.out_ready = 1'b0;
        put(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0);
        @(posedge clk); #1;
        put(1'b1, 32'h89AB_CDEF, 32'h7654_3210, 1'b1);
        @(posedge clk); #1;
        put(1'b1, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("stall_ready", 64'(bus.in_ready), 64'(0));
            check("stall_valid", 64'(bus.out_valid), 64'(1));
            check("stall_sum", 64'(bus.Sum), 64'(32'h0000_0030));
            check("stall_cout", 64'(bus.Cout), 64'(0));
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_obs(3);
        if (obs_res.size() >= 3) begin
            check("stall_r0", 64'(obs_res[0][32:0]), 64'({1'b0, 32'h0000_0030}));
            check("stall_r1", 64'(obs_res[1][32:0]), 64'({1'b1, 32'h0000_0000}));
            check("stall_r2", 64'(obs_res[2][32:0]), 64'({1'b0, 32'hFFFF_FFFF}));
        end

        // Reset with two operations in flight.
        repeat (3) @(posedge clk);
        #1;
        clear_obs();
        put(1'b1, 32'h0000_0001, 32'h0000_0002, 1'b0);
        @(posedge clk); #1;
        put(1'b1, 32'hFFFF_0000, 32'h0001_FFFF, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_valid", 64'(bus.out_valid), 64'(0));
        check("rst_mid_sum", 64'(bus.Sum), 64'(0));
        check("rst_mid_cout", 64'(bus.Cout), 64'(0));
        check("rst_mid_ready", 64'(bus.in_ready), 64'(1));
        repeat (5) @(posedge clk);
        #1;
        check("rst_no_stale", 64'(obs_res.size()), 64'(0));

        // Randomized traffic with random backpressure.
        for (int n = 0; n < 400; n++) begin
            if (!(bus.in_valid && !bus.in_ready)) begin
                put($urandom_range(0, 9) < 6, pick_op(), pick_op(), 1'($urandom_range(0, 1)));
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("drain_sb", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
